// File: rtl/imm_decode_stage_pkg.sv
// Shared opcodes, immediate-format codes and XLEN legality for the immediate-decode stage.
// Combinational definitions only; no latency or flow control here.
package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream valid-ready bundle of the immediate-decode stage.
// master = testbench/neighbour side, slave = the stage itself.
interface imm_decode_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_imm, out_fmt
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_imm, out_fmt
    );
endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational RV32/RV64 immediate extractor (zero latency, no flow control).
// IMM_DECODE_ZIMM_EN adds the CSR*I zimm format; otherwise those decode as NONE.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o
);
    localparam bit IS64 = (XLEN == 64);

    logic [6:0] op;
    logic [2:0] f3;

    assign op = inst_i[6:0];
    assign f3 = inst_i[14:12];

    // Size casts of signed operands sign-extend straight to XLEN (U is extended from bit 31).
    always_comb begin
        fmt_o = FMT_NONE;
        imm_o = '0;
        case (op)
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt_o = FMT_SH;
                    imm_o = IS64 ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
                end else begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'($signed(inst_i[31:20]));
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt_o = FMT_I;
                imm_o = XLEN'($signed(inst_i[31:20]));
            end
            OP_IMM32: begin
                if (IS64 && f3 == 3'b000) begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'($signed(inst_i[31:20]));
                end else if (IS64 && (f3 == 3'b001 || f3 == 3'b101)) begin
                    fmt_o = FMT_SH;
                    imm_o = XLEN'(inst_i[24:20]);
                end
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                       inst_i[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                       inst_i[30:21], 1'b0}));
            end
`ifdef IMM_DECODE_ZIMM_EN
            OP_SYSTEM: begin
                if (f3[2]) begin
                    fmt_o = FMT_Z;
                    imm_o = XLEN'(inst_i[19:15]);
                end
            end
`endif
            default: begin
                fmt_o = FMT_NONE;
                imm_o = '0;
            end
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: 1-cycle latency, main + skid entry; in_ready = !skid_valid (registered).
// Backpressure holds outputs stable; flush drops everything held. IMM_DECODE_ZIMM_EN selects zimm decode.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit PASS_INST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    imm_decode_stage_if.slave  bus
);
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
    } entry_t;

    entry_t          in_ent;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    logic            main_vld_q, main_vld_d;
    logic            skid_vld_q, skid_vld_d;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            accept;
    logic            drain;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst_i (bus.in_inst),
        .imm_o  (dec_imm),
        .fmt_o  (dec_fmt)
    );

    assign in_ent.inst = PASS_INST ? bus.in_inst : 32'd0;
    assign in_ent.imm  = dec_imm;
    assign in_ent.fmt  = dec_fmt;

    assign accept = bus.in_valid & ~skid_vld_q;
    assign drain  = main_vld_q & bus.out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            // Main is free this edge: the older skid entry has priority over a new beat.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_d = in_ent;
                end
            end
        end else if (accept) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign bus.in_ready  = ~skid_vld_q;
    assign bus.out_valid = main_vld_q;
    assign bus.out_inst  = main_q.inst;
    assign bus.out_imm   = main_q.imm;
    assign bus.out_fmt   = main_q.fmt;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Drives identical traffic into an XLEN=32 and an XLEN=64 stage and scoreboards both
// against an arithmetic reference decoder.
`timescale 1ns/1ps
module tb_imm_decode_stage;
    import imm_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = 32'd0;
    logic        out_ready = 1'b0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q32[$];
    exp_t        q64[$];

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_inst   = in_inst;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.in_inst   = in_inst;
    assign b64.out_ready = out_ready;

    imm_decode_stage #(.XLEN(32), .PASS_INST(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32)
    );
    imm_decode_stage #(.XLEN(64), .PASS_INST(1'b1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder: field arithmetic on a 64-bit signed value.
    function automatic exp_t model(logic [31:0] x, bit rv64);
        exp_t   e;
        longint sx;
        longint v;
        int     fmt;
        int     f3;
        sx  = longint'($signed(x));
        f3  = int'(x[14:12]);
        v   = 0;
        fmt = 0;
        case (x[6:0])
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    fmt = 6;
                    v   = rv64 ? longint'(x[25:20]) : longint'(x[24:20]);
                end else begin
                    fmt = 1;
                    v   = sx >>> 20;
                end
            end
            7'h03, 7'h67: begin fmt = 1; v = sx >>> 20; end
            7'h1B: begin
                if (rv64 && f3 == 0) begin fmt = 1; v = sx >>> 20; end
                else if (rv64 && (f3 == 1 || f3 == 5)) begin fmt = 6; v = longint'(x[24:20]); end
            end
            7'h23: begin fmt = 2; v = ((sx >>> 25) <<< 5) + longint'(x[11:7]); end
            7'h63: begin
                fmt = 3;
                v = ((sx >>> 31) <<< 12) + (longint'(x[7]) << 11)
                  + (longint'(x[30:25]) << 5) + (longint'(x[11:8]) << 1);
            end
            7'h37, 7'h17: begin fmt = 4; v = (sx >>> 12) <<< 12; end
            7'h6F: begin
                fmt = 5;
                v = ((sx >>> 31) <<< 20) + (longint'(x[19:12]) << 12)
                  + (longint'(x[20]) << 11) + (longint'(x[30:21]) << 1);
            end
`ifdef IMM_DECODE_ZIMM_EN
            7'h73: if (x[14]) begin fmt = 7; v = longint'(x[19:15]); end
`endif
            default: begin fmt = 0; v = 0; end
        endcase
        e.inst = x;
        e.imm  = rv64 ? 64'(v) : {32'd0, 32'(v)};
        e.fmt  = 3'(fmt);
        return e;
    endfunction

    // Acceptance tracker: pushes on every input handshake, empties on reset/flush.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (in_valid && b32.in_ready) q32.push_back(model(in_inst, 1'b0));
            if (in_valid && b64.in_ready) q64.push_back(model(in_inst, 1'b1));
        end
    end

    // Monitor: occupancy (out_valid / in_ready) against held count, then content on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("occ_valid32", 64'(b32.out_valid), 64'(q32.size() > 0));
            check("occ_ready32", 64'(b32.in_ready), 64'(q32.size() < 2));
            check("occ_valid64", 64'(b64.out_valid), 64'(q64.size() > 0));
            check("occ_ready64", 64'(b64.in_ready), 64'(q64.size() < 2));
            if (b32.out_valid && out_ready && q32.size() > 0) begin
                e = q32.pop_front();
                check("inst32", 64'(b32.out_inst), 64'(e.inst));
                check("imm32", 64'(b32.out_imm), e.imm);
                check("fmt32", 64'(b32.out_fmt), 64'(e.fmt));
            end
            if (b64.out_valid && out_ready && q64.size() > 0) begin
                e = q64.pop_front();
                check("inst64", 64'(b64.out_inst), 64'(e.inst));
                check("imm64", b64.out_imm, e.imm);
                check("fmt64", 64'(b64.out_fmt), 64'(e.fmt));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] x);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_inst  = x;
        for (int n = 0; n < 64 && !acc; n++) begin
            acc = b32.in_ready && !flush;
            cyc();
        end
        check("accept_in_time", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int n = 0; n < 20 && (q32.size() > 0 || q64.size() > 0); n++) cyc();
        check("drained32", 64'(q32.size()), 64'd0);
        check("drained64", 64'(q64.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] x;
        ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h00};
        x = $urandom;
        x[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 7) == 0) x[6:0] = 7'($urandom);
        return x;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check("rst_out_imm", b64.out_imm, 64'd0);
        check("rst_out_fmt", 64'(b32.out_fmt), 64'(FMT_NONE));
        check("rst_out_inst", 64'(b64.out_inst), 64'd0);
        mon_en = 1'b1;

        out_ready = 1'b1;
        send(32'hFFF00093);
        @(negedge clk);
        check("addi_valid", 64'(b32.out_valid), 64'd1);
        check("addi_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
        check("addi_fmt", 64'(b32.out_fmt), 64'(FMT_I));
        cyc();

        send(32'hFE000EE3);
        @(negedge clk);
        check("beq_imm", 64'(b32.out_imm), 64'hFFFFFFFC);
        check("beq_fmt", 64'(b32.out_fmt), 64'(FMT_B));
        check("b2b_ready", 64'(b32.in_ready), 64'd1);
        send(32'h001000EF);
        @(negedge clk);
        check("jal_imm", 64'(b32.out_imm), 64'h00000800);
        check("jal_fmt", 64'(b32.out_fmt), 64'(FMT_J));

        send(32'h123450B7);
        @(negedge clk);
        check("lui64_imm", b64.out_imm, 64'h0000000012345000);
        check("lui64_fmt", 64'(b64.out_fmt), 64'(FMT_U));
        send(32'h800000B7);
        @(negedge clk);
        check("luineg64_imm", b64.out_imm, 64'hFFFFFFFF80000000);
        send(32'h02509093);
        @(negedge clk);
        check("slli64_imm", b64.out_imm, 64'd37);
        check("slli64_fmt", 64'(b64.out_fmt), 64'(FMT_SH));
        check("slli32_imm", 64'(b32.out_imm), 64'd5);
        drain();

        // Stall: A held, B into skid, C refused until downstream opens.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00A00093;
        cyc();
        in_inst   = 32'h00B00113;
        cyc();
        in_inst   = 32'h00C00193;
        @(negedge clk);
        check("stall_ready", 64'(b32.in_ready), 64'd0);
        check("stall_hold_a", 64'(b32.out_inst), 64'h00A00093);
        cyc();
        @(negedge clk);
        check("stall_still_a", 64'(b32.out_inst), 64'h00A00093);
        check("stall_len", 64'(q32.size()), 64'd2);
        out_ready = 1'b1;
        send(32'h00C00193);
        drain();

        // Flush with skid full and a beat offered in the same cycle.
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        in_valid = 1'b1;
        in_inst  = 32'h00300193;
        flush    = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(b32.out_valid), 64'd0);
        check("flush_ready", 64'(b64.in_ready), 64'd1);
        cyc();
        @(negedge clk);
        check("flush_drop_c", 64'(b32.out_valid), 64'd0);

        // Reset in the middle of a stall.
        send(32'hFFF00093);
        send(32'h001000EF);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_valid", 64'(b32.out_valid), 64'd0);
        check("rst2_ready", 64'(b32.in_ready), 64'd1);
        check("rst2_imm", b64.out_imm, 64'd0);
        check("rst2_fmt", 64'(b64.out_fmt), 64'(FMT_NONE));
        out_ready = 1'b1;
        send(32'h0002D073);
        @(negedge clk);
`ifdef IMM_DECODE_ZIMM_EN
        check("csrrwi_fmt", 64'(b32.out_fmt), 64'(FMT_Z));
        check("csrrwi_imm", 64'(b32.out_imm), 64'd5);
`else
        check("csrrwi_fmt", 64'(b32.out_fmt), 64'(FMT_NONE));
        check("csrrwi_imm", 64'(b32.out_imm), 64'd0);
`endif
        drain();

        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        flush = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered, parametrised RV32/RV64 immediate-generation stage that sits between fetch and the register-read/execute stage. It accepts one instruction per cycle over a valid/ready handshake and decodes its immediate, sign- or zero-extended to XLEN. It also reports the immediate format and forwards the instruction. A 2-entry skid buffer keeps in_ready fully registered, and a flush input discards in-flight entries on redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (any other value: elaboration error)
PASS_INST, 1, 1 = forward the instruction on out_inst; 0 = out_inst tied to 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
flush  input  1  discard all held entries this cycle
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction
in_inst  input  32  raw instruction
out_valid  output  1  decoded entry available
out_ready  input  1  downstream accepts the entry
out_inst  output  32  instruction of the presented entry
out_imm  output  XLEN  extended immediate
out_fmt  output  3  format code (see Decomposition)

Behaviour:
- Reset (rst_n=0 at posedge): main_valid=0, skid_valid=0. Outputs after reset: out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE, out_inst=0. Reset overrides flush and handshakes.
- Handshake: transfer occurs on a cycle with valid&ready. Latency is 1 cycle: an instruction accepted in cycle N is presented in cycle N+1 when the stage was empty.
- Storage: main register drives outputs. Skid register captures an accepted entry while main is held (out_valid&!out_ready). in_ready = !skid_valid, registered with no combinational path from out_ready.
- Skid promotion: when main drains and skid_valid=1, skid moves to main the same edge. Entries stay in order; out_* hold stable while out_valid&!out_ready.
- Flush: at the clock edge, main_valid=0 and skid_valid=0. An in_valid beat in the same cycle is dropped even if in_ready=1. Flush wins over everything except reset.
- Decode is combinational on in_inst; the result is captured into the register with the instruction. Here op=inst[6:0], f3=inst[14:12].
  - op 0010011 (f3 != 001/101), 0000011, 1100111: fmt I, imm = sext(inst[31:20]).
  - op 0010011 with f3 001/101: fmt SH. imm = zext(inst[24:20]) when XLEN=32, zext(inst[25:20]) when XLEN=64.
  - op 0011011 (XLEN=64 only): f3 000 gives fmt I; f3 001/101 gives fmt SH, imm = zext(inst[24:20]). When XLEN=32 it is NONE.
  - op 0100011: fmt S, imm = sext({inst[31:25],inst[11:7]}).
  - op 1100011: fmt B, imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - op 0110111 / 0010111: fmt U, imm = sext({inst[31:12],12'b0}). With XLEN=64 the result is sign-extended from bit 31.
  - op 1101111: fmt J, imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Any other opcode: fmt NONE, imm=0. No latch-like holding of a previous value.
- Simultaneous accept and drain with skid empty: main is reloaded with the new entry, and out_valid stays 1.

Optional Feature:
Macro IMM_DECODE_ZIMM_EN.
- Defined: op 1110011 with f3[2]=1 (CSRRWI/CSRRSI/CSRRCI) decodes as fmt Z, imm = zext(inst[19:15]).
- Undefined: these instructions decode as NONE with imm=0, and code 7 never appears on out_fmt.

Decomposition:
- Package imm_pkg holds:
  - the opcode constants;
  - the fmt enum: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7;
  - the XLEN legality check.
- One sub-module, imm_extract: purely combinational (inst, XLEN) to (imm, fmt). It is instantiated once, ahead of the input register.

Test Plan:
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=I.
- Push 0xFE000EE3 (beq -4), then 0x001000EF (jal x1,+2048), back-to-back:
  - out_imm=0xFFFFFFFC fmt B, then 0x00000800 fmt J, on consecutive cycles;
  - in_ready stays 1.
- XLEN=64, push 0x123450B7 (lui) and 0x800000B7 (lui x1,0x80000), then 0x02509093 (slli x1,x1,37):
  - imm=0x0000000012345000 (U), 0xFFFFFFFF80000000 (U);
  - then 37 (SH).
- out_ready=0, push A, B, C on consecutive cycles:
  - A held on outputs, B enters skid, in_ready=0 from the cycle after B, C not accepted;
  - raising out_ready yields A, B, then C in order with no loss or duplication.
- With A in main and B in skid, assert flush with in_valid=1 (C) -> next cycle out_valid=0, in_ready=1, C dropped.
- rst_n=0 for one edge mid-stall -> out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE. With the macro defined, push 0x0002D073 (csrrwi x0,0x000,5) -> fmt Z, imm=5; without the macro -> fmt NONE, imm=0.
